// File: rtl/ixc_gfifo_pkg.sv
// Shared definitions for the token-driven global-FIFO port: FSM state
// encoding and default widths.
package ixc_gfifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_HOLD = 2'd2,
    ST_PASS = 2'd3
  } gf_state_e;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_DEPTH     = 4;
  localparam int DEF_CBID_W    = 20;
  localparam int DEF_LEN_W     = 12;
  localparam int DEF_OUT_W     = 512;
  localparam int DEF_MAX_BURST = 4;

endpackage

// File: rtl/ixc_gfifo_lbuf.sv
// Local request buffer: power-of-two circular FIFO with occupancy count.
// Push is refused while full even if a pop happens the same cycle.
module ixc_gfifo_lbuf
  import ixc_gfifo_pkg::*;
#(
  parameter int ENT_W = DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                       fclk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [ENT_W-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [ENT_W-1:0]           rdata_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q];
  assign level_o = level_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (do_push) wptr_d = wptr_q + PTR_W'(1);
    if (do_pop)  rptr_d = rptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge fclk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/ixc_gfifo_port_p.sv
// Global-FIFO port: captures toggle-encoded requests into a local buffer and
// drains up to MAX_BURST entries to the shared FIFO while holding the token.
module ixc_gfifo_port_p
  import ixc_gfifo_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int CBID_W    = DEF_CBID_W,
  parameter int LEN_W     = DEF_LEN_W,
  parameter int OUT_W     = DEF_OUT_W,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                       fclk,
  input  logic                       rst_n,
  input  logic                       ireq,
  input  logic [CBID_W-1:0]          cbid,
  input  logic [LEN_W-1:0]           len,
  input  logic [DATA_W-1:0]          idata,
  input  logic                       lock,
  input  logic                       tkin,
  output logic                       tkout,
  output logic                       gf_req,
  output logic [CBID_W-1:0]          gf_cbid,
  output logic [LEN_W-1:0]           gf_len,
  output logic [OUT_W-1:0]           gf_data,
  input  logic                       gf_full,
  output logic                       lb_full,
  output logic [$clog2(DEPTH):0]     lb_level
);

  localparam int ENT_W   = CBID_W + LEN_W + DATA_W;
  localparam int LVL_W   = $clog2(DEPTH) + 1;
  localparam int BURST_W = $clog2(MAX_BURST + 1);

  gf_state_e          state_q, state_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [BURST_W-1:0] burst_inc;
  logic               ireq_q;
  logic               accept;
  logic               pop;
  logic               lb_empty;
  logic [ENT_W-1:0]   head;
  logic [CBID_W-1:0]  head_cbid;
  logic [LEN_W-1:0]   head_len;
  logic [DATA_W-1:0]  head_data;

  // A request stays pending (ireq_q held) until buffer space and lock allow it.
  assign accept    = (ireq != ireq_q) && !lock && !lb_full;
  assign burst_inc = burst_q + BURST_W'(1);
  assign {head_cbid, head_len, head_data} = head;

  ixc_gfifo_lbuf #(
    .ENT_W (ENT_W),
    .DEPTH (DEPTH)
  ) u_lbuf (
    .fclk    (fclk),
    .rst_n   (rst_n),
    .push_i  (accept),
    .wdata_i ({cbid, len, idata}),
    .pop_i   (pop),
    .rdata_o (head),
    .level_o (lb_level),
    .full_o  (lb_full),
    .empty_o (lb_empty)
  );

  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    gf_req  = 1'b0;
    tkout   = 1'b0;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        burst_d = '0;
        if (tkin) begin
          if (lb_empty || lock) state_d = ST_PASS;
          else if (!gf_full)    state_d = ST_SEND;
          else                  state_d = ST_HOLD;
        end
      end
      ST_SEND: begin
        if (lb_empty) begin
          state_d = ST_PASS;
        end else if (gf_full || lock) begin
          state_d = ST_HOLD;
        end else begin
          gf_req  = 1'b1;
          pop     = 1'b1;
          burst_d = burst_inc;
          if (lb_level == LVL_W'(1) || burst_inc == BURST_W'(MAX_BURST))
            state_d = ST_PASS;
        end
      end
      ST_HOLD: begin
        if (lb_empty)              state_d = ST_PASS;
        else if (!gf_full && !lock) state_d = ST_SEND;
      end
      ST_PASS: begin
        tkout   = 1'b1;
        burst_d = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Entry fields are driven only while the write strobe is active.
  always_comb begin
    gf_cbid = '0;
    gf_len  = '0;
    gf_data = '0;
    if (gf_req) begin
      gf_cbid              = head_cbid;
      gf_len               = head_len;
      gf_data[DATA_W-1:0]  = head_data;
    end
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      burst_q <= '0;
      ireq_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      if (accept) ireq_q <= ireq;
    end
  end

endmodule

// File: tb/tb_ixc_gfifo_port_p.sv
// Bench for ixc_gfifo_port_p: cycle table plus hand sequences for full,
// stall, burst-limit and reset corners; payload order checked by a scoreboard.
module tb_ixc_gfifo_port_p;

  localparam int DATA_W = 8, DEPTH = 4, CBID_W = 20, LEN_W = 12;
  localparam int OUT_W = 512, MAX_BURST = 4, LVL_W = 3;

  logic              fclk = 1'b0;
  logic              rst_n;
  logic              ireq, lock, tkin, gf_full;
  logic [CBID_W-1:0] cbid;
  logic [LEN_W-1:0]  len;
  logic [DATA_W-1:0] idata;
  logic              tkout, gf_req, lb_full;
  logic [CBID_W-1:0] gf_cbid;
  logic [LEN_W-1:0]  gf_len;
  logic [OUT_W-1:0]  gf_data;
  logic [LVL_W-1:0]  lb_level;

  ixc_gfifo_port_p #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .CBID_W(CBID_W), .LEN_W(LEN_W),
    .OUT_W(OUT_W), .MAX_BURST(MAX_BURST)
  ) dut (
    .fclk(fclk), .rst_n(rst_n), .ireq(ireq), .cbid(cbid), .len(len),
    .idata(idata), .lock(lock), .tkin(tkin), .tkout(tkout),
    .gf_req(gf_req), .gf_cbid(gf_cbid), .gf_len(gf_len), .gf_data(gf_data),
    .gf_full(gf_full), .lb_full(lb_full), .lb_level(lb_level)
  );

  always #5 fclk = ~fclk;

  typedef struct {
    logic [CBID_W-1:0] cbid;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] data;
  } ent_t;

  typedef struct {
    bit         tog;
    bit         lk;
    bit         tk;
    bit         gff;
    logic [7:0] din;
    bit         e_req;
    bit         e_tk;
    int         e_lvl;
  } vec_t;

  ent_t sb_q[$];
  vec_t tbl[20];
  int   nvec = 0, nerr = 0, n_sent = 0, n_tk = 0;

  function automatic ent_t mk_ent(input logic [7:0] d);
    ent_t e;
    e.cbid = CBID_W'({d, 4'h5});
    e.len  = {4'hF, d};
    e.data = d;
    return e;
  endfunction

  function automatic vec_t mkv(input bit tog, input bit lk, input bit tk, input bit gff,
                               input logic [7:0] din, input bit er, input bit et, input int el);
    vec_t v;
    v.tog = tog; v.lk = lk; v.tk = tk; v.gff = gff; v.din = din;
    v.e_req = er; v.e_tk = et; v.e_lvl = el;
    return v;
  endfunction

  task automatic tick();
    @(posedge fclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send_req(input logic [7:0] d);
    ent_t e;
    e = mk_ent(d);
    cbid  = e.cbid;
    len   = e.len;
    idata = e.data;
    ireq  = ~ireq;
    sb_q.push_back(e);
  endtask

  task automatic wait_tk(input string name, input int lim);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < lim && !seen; i++) begin
      tick();
      if (tkout) seen = 1'b1;
    end
    nvec++;
    if (!seen) begin
      nerr++;
      $display("FAIL %s: tkout not seen within %0d cycles", name, lim);
    end
  endtask

  // Output monitor: every write strobe must match the oldest expected entry,
  // and entry fields must be zero when no strobe is present.
  always @(negedge fclk) begin
    ent_t e;
    if (rst_n) begin
      if (gf_req) begin
        n_sent++;
        nvec++;
        if (sb_q.size() == 0) begin
          nerr++;
          $display("FAIL sb_unexpected: got data %0h, expected no write", gf_data[DATA_W-1:0]);
        end else begin
          e = sb_q.pop_front();
          if (gf_cbid !== e.cbid || gf_len !== e.len || gf_data !== OUT_W'(e.data)) begin
            nerr++;
            $display("FAIL sb_entry: got %0h/%0h/%0h, expected %0h/%0h/%0h",
                     gf_cbid, gf_len, gf_data[DATA_W-1:0], e.cbid, e.len, e.data);
          end
        end
      end else begin
        nvec++;
        if (gf_cbid !== '0 || gf_len !== '0 || gf_data !== '0) begin
          nerr++;
          $display("FAIL idle_fields: got %0h/%0h/%0h, expected 0/0/0",
                   gf_cbid, gf_len, gf_data[DATA_W-1:0]);
        end
      end
      if (tkout) n_tk++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int sent0, tk0;
    ent_t e;
    rst_n = 1'b0; ireq = 1'b0; lock = 1'b0; tkin = 1'b0; gf_full = 1'b0;
    cbid = '0; len = '0; idata = '0;

    tbl[0]  = mkv(1, 0, 0, 0, 8'h11, 0, 0, 1);
    tbl[1]  = mkv(1, 0, 0, 0, 8'h22, 0, 0, 2);
    tbl[2]  = mkv(1, 0, 0, 0, 8'h33, 0, 0, 3);
    tbl[3]  = mkv(0, 0, 1, 0, 8'h00, 1, 0, 3);
    tbl[4]  = mkv(0, 0, 1, 0, 8'h00, 1, 0, 2);
    tbl[5]  = mkv(0, 0, 0, 0, 8'h00, 1, 0, 1);
    tbl[6]  = mkv(0, 0, 0, 0, 8'h00, 0, 1, 0);
    tbl[7]  = mkv(0, 0, 0, 0, 8'h00, 0, 0, 0);
    tbl[8]  = mkv(0, 0, 1, 0, 8'h00, 0, 1, 0);
    tbl[9]  = mkv(0, 0, 0, 0, 8'h00, 0, 0, 0);
    tbl[10] = mkv(1, 1, 0, 0, 8'h44, 0, 0, 0);
    tbl[11] = mkv(0, 1, 1, 0, 8'h00, 0, 1, 0);
    tbl[12] = mkv(0, 0, 0, 0, 8'h00, 0, 0, 1);
    tbl[13] = mkv(0, 1, 1, 0, 8'h00, 0, 1, 1);
    tbl[14] = mkv(0, 0, 1, 0, 8'h00, 0, 0, 1);
    tbl[15] = mkv(0, 0, 1, 1, 8'h00, 0, 0, 1);
    tbl[16] = mkv(0, 0, 0, 1, 8'h00, 0, 0, 1);
    tbl[17] = mkv(0, 0, 0, 0, 8'h00, 1, 0, 1);
    tbl[18] = mkv(0, 0, 0, 0, 8'h00, 0, 1, 0);
    tbl[19] = mkv(0, 0, 0, 0, 8'h00, 0, 0, 0);

    // Reset state
    repeat (2) @(posedge fclk);
    #1;
    chk("rst_gf_req", 64'(gf_req), 64'(0));
    chk("rst_tkout", 64'(tkout), 64'(0));
    chk("rst_lb_full", 64'(lb_full), 64'(0));
    chk("rst_lb_level", 64'(lb_level), 64'(0));
    rst_n = 1'b1;
    tick();

    // Cycle table
    for (int i = 0; i < 20; i++) begin
      if (tbl[i].tog) send_req(tbl[i].din);
      lock    = tbl[i].lk;
      tkin    = tbl[i].tk;
      gf_full = tbl[i].gff;
      tick();
      chk($sformatf("tbl%0d_gf_req", i), 64'(gf_req), 64'(tbl[i].e_req));
      chk($sformatf("tbl%0d_tkout", i), 64'(tkout), 64'(tbl[i].e_tk));
      chk($sformatf("tbl%0d_level", i), 64'(lb_level), 64'(tbl[i].e_lvl));
    end
    lock = 1'b0; tkin = 1'b0; gf_full = 1'b0;
    chk("tbl_sb_drained", 64'(sb_q.size()), 64'(0));

    // Overfill with one pending request, then stall mid-burst
    for (int k = 0; k < 5; k++) begin
      send_req(8'hA0 + 8'(k));
      tick();
    end
    chk("ovf_level", 64'(lb_level), 64'(4));
    chk("ovf_full", 64'(lb_full), 64'(1));
    tick();
    chk("ovf_pending_level", 64'(lb_level), 64'(4));
    tkin = 1'b1;
    tick();
    tkin = 1'b0;
    sent0 = n_sent;
    chk("ovf_send_req", 64'(gf_req), 64'(1));
    tick();
    chk("ovf_pop_full_refuse", 64'(lb_level), 64'(3));
    gf_full = 1'b1;
    tick();
    chk("hold_level", 64'(lb_level), 64'(4));
    chk("hold_full", 64'(lb_full), 64'(1));
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("hold%0d_gf_req", k), 64'(gf_req), 64'(0));
      chk($sformatf("hold%0d_tkout", k), 64'(tkout), 64'(0));
      if (k < 2) tick();
    end
    gf_full = 1'b0;
    wait_tk("hold_resume_tk", 20);
    chk("hold_burst_count", 64'(n_sent - sent0), 64'(4));
    chk("hold_left_level", 64'(lb_level), 64'(1));
    tick();
    tkin = 1'b1;
    tick();
    tkin = 1'b0;
    wait_tk("hold_drain_tk", 10);
    chk("hold_drain_level", 64'(lb_level), 64'(0));
    chk("hold_sb_drained", 64'(sb_q.size()), 64'(0));
    tick();

    // Six entries against MAX_BURST=4, refilling while sending
    for (int k = 0; k < 4; k++) begin
      send_req(8'hB0 + 8'(k));
      tick();
    end
    chk("burst_fill_level", 64'(lb_level), 64'(4));
    tkin = 1'b1;
    tick();
    tkin = 1'b0;
    sent0 = n_sent;
    send_req(8'hB4);
    tick();
    tick();
    send_req(8'hB5);
    tick();
    tick();
    chk("burst_tkout", 64'(tkout), 64'(1));
    chk("burst_count", 64'(n_sent - sent0), 64'(4));
    chk("burst_left_level", 64'(lb_level), 64'(2));
    tick();
    tkin = 1'b1;
    tick();
    tkin = 1'b0;
    sent0 = n_sent;
    wait_tk("burst2_tk", 10);
    chk("burst2_count", 64'(n_sent - sent0), 64'(2));
    chk("burst2_level", 64'(lb_level), 64'(0));
    chk("burst_sb_drained", 64'(sb_q.size()), 64'(0));
    tick();

    // Reset while sending; ireq high at release counts as a request
    send_req(8'hC0);
    tick();
    send_req(8'hC1);
    tick();
    tkin = 1'b1;
    tick();
    tkin = 1'b0;
    chk("mid_send_req", 64'(gf_req), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_gf_req", 64'(gf_req), 64'(0));
    chk("arst_tkout", 64'(tkout), 64'(0));
    chk("arst_level", 64'(lb_level), 64'(0));
    chk("arst_gf_data", 64'(gf_data[63:0]), 64'(0));
    sb_q.delete();
    tk0 = n_tk;
    e = mk_ent(8'h5A);
    cbid = e.cbid; len = e.len; idata = e.data;
    ireq = 1'b1;
    sb_q.push_back(e);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rel_ireq_level", 64'(lb_level), 64'(1));
    repeat (3) tick();
    chk("rel_no_tkout", 64'(n_tk - tk0), 64'(0));
    tkin = 1'b1;
    tick();
    tkin = 1'b0;
    wait_tk("rel_drain_tk", 10);
    chk("rel_drain_level", 64'(lb_level), 64'(0));
    tick();
    chk("rel_sb_drained", 64'(sb_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
